// File: rtl/jpeg_spi_buf_ctrl.sv
// ---------------------------------------------------------------------------
// jpeg_spi_buf_ctrl
//
// Ring-buffer controller that shares one single-port byte RAM between the
// JPEG encoder (writer) and the SPI slave readout path (reader). The head
// byte is prefetched into a register so mem_data stays stable for the SPI
// slave. One byte is popped per mem_rd pulse. The number of complete frames
// held in the buffer is tracked for host polling.
//
// Parameters
//   ADDR_W      RAM address width, capacity DEPTH = 2**ADDR_W bytes
//   EMPTY_BYTE  value shown on mem_data when no head byte is held
//
// Ports
//   clk        single clock for all logic and the RAM
//   reset      synchronous active-high reset
//   flush      one-cycle pulse, empties the buffer (same effect as reset)
//   enc_wr     encoder byte strobe, taken only when enc_ready=1
//   enc_data   encoder byte
//   enc_eof    enc_data is the last byte of a frame
//   enc_ready  a byte can be accepted this cycle
//   mem_rd     one-cycle pop pulse from the SPI slave
//   mem_data   current head byte or EMPTY_BYTE
//   ram_en     RAM access enable (registered)
//   ram_we     RAM write enable, 1 = write (registered)
//   ram_addr   RAM address (registered)
//   ram_wdata  RAM write data {eof, data} (registered)
//   ram_rdata  RAM read data {eof, data}
//   frame_cnt  complete frames in the buffer, saturating
//   underrun   sticky, set by mem_rd with no head byte
// ---------------------------------------------------------------------------
module jpeg_spi_buf_ctrl #(
    parameter int         ADDR_W     = 17,
    parameter logic [7:0] EMPTY_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              enc_wr,
    input  logic [7:0]        enc_data,
    input  logic              enc_eof,
    output logic              enc_ready,
    input  logic              mem_rd,
    output logic [7:0]        mem_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [8:0]        ram_wdata,
    input  logic [8:0]        ram_rdata,
    output logic [7:0]        frame_cnt,
    output logic              underrun
);

    // DEPTH held with two spare bits so ram_cnt + hold_vld cannot overflow
    localparam logic [ADDR_W+1:0] DEPTH_L = {2'b01, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              hold_vld;
    logic [8:0]        hold_q;
    logic              head_vld;
    logic [8:0]        head_q;
    logic              rd_pend;

    logic [ADDR_W+1:0] fill_lvl;
    logic              rd_need;
    logic              wr_go;
    logic              accept;
    logic              pop_head;
    logic              pop_land;
    logic              frame_inc;
    logic              frame_dec;

    // A prefetch is needed whenever the head is empty, nothing is in flight
    // and the RAM still holds unfetched bytes. It always wins the RAM port.
    assign rd_need  = !head_vld && !rd_pend && (ram_cnt != '0);
    assign fill_lvl = {1'b0, ram_cnt} + {{(ADDR_W+1){1'b0}}, hold_vld};
    assign wr_go    = hold_vld && !rd_need && ({1'b0, ram_cnt} < DEPTH_L);

    // Hold may only be refilled if its current byte is guaranteed to commit
    // this cycle, i.e. no prefetch is stealing the RAM port.
    assign enc_ready = (fill_lvl < DEPTH_L) && (!hold_vld || !rd_need);
    assign accept    = enc_wr && enc_ready;

    // rd_pend and head_vld are never both set, so a pop during a landing
    // consumes the landing byte directly.
    assign pop_head  = mem_rd && head_vld;
    assign pop_land  = mem_rd && rd_pend;
    assign frame_inc = accept && enc_eof;
    assign frame_dec = (pop_head && head_q[8]) || (pop_land && ram_rdata[8]);

    assign mem_data = head_vld ? head_q[7:0] : EMPTY_BYTE;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            hold_vld  <= 1'b0;
            hold_q    <= '0;
            head_vld  <= 1'b0;
            head_q    <= '0;
            rd_pend   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            frame_cnt <= '0;
            underrun  <= 1'b0;
        end else begin
            rd_pend <= rd_need;

            // RAM arbitration: the access is decided here and driven on the
            // registered RAM outputs during the following cycle.
            if (rd_need) begin
                rd_ptr   <= rd_ptr + ADDR_W'(1);
                ram_cnt  <= ram_cnt - (ADDR_W+1)'(1);
                ram_en   <= 1'b1;
                ram_we   <= 1'b0;
                ram_addr <= rd_ptr;
            end else if (wr_go) begin
                wr_ptr    <= wr_ptr + ADDR_W'(1);
                ram_cnt   <= ram_cnt + (ADDR_W+1)'(1);
                ram_en    <= 1'b1;
                ram_we    <= 1'b1;
                ram_addr  <= wr_ptr;
                ram_wdata <= hold_q;
            end else begin
                ram_en <= 1'b0;
                ram_we <= 1'b0;
            end

            if (accept) begin
                hold_q   <= {enc_eof, enc_data};
                hold_vld <= 1'b1;
            end else if (wr_go) begin
                hold_vld <= 1'b0;
            end

            // Landing first, then the pop: a same-cycle pop discards the
            // landing byte so it never appears on mem_data.
            if (rd_pend) begin
                head_q   <= ram_rdata;
                head_vld <= !mem_rd;
            end else if (pop_head) begin
                head_vld <= 1'b0;
            end

            if (mem_rd && !head_vld && !rd_pend) begin
                underrun <= 1'b1;
            end

            if (frame_inc && !frame_dec && (frame_cnt != 8'hFF)) begin
                frame_cnt <= frame_cnt + 8'd1;
            end else if (frame_dec && !frame_inc && (frame_cnt != 8'h00)) begin
                frame_cnt <= frame_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_spi_buf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jpeg_spi_buf_ctrl
//
// Bench for jpeg_spi_buf_ctrl with a 16-byte RAM (ADDR_W=4) modelled as an
// asynchronous-read, clocked-write array. A cycle-by-cycle vector table
// covers the basic flow; directed sequences cover underrun, full/wrap,
// contention, flush and frame counting.
// ---------------------------------------------------------------------------
module tb_jpeg_spi_buf_ctrl;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          enc_wr = 1'b0;
    logic [7:0]    enc_data = 8'h00;
    logic          enc_eof = 1'b0;
    logic          enc_ready;
    logic          mem_rd = 1'b0;
    logic [7:0]    mem_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [8:0]    ram_wdata;
    logic [8:0]    ram_rdata;
    logic [7:0]    frame_cnt;
    logic          underrun;

    int testsRun = 0;
    int testsFailed = 0;
    int badAccess = 0;
    int wrAddrQ[$];

    jpeg_spi_buf_ctrl #(.ADDR_W(AW), .EMPTY_BYTE(8'hFF)) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .enc_wr(enc_wr),
        .enc_data(enc_data),
        .enc_eof(enc_eof),
        .enc_ready(enc_ready),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .ram_en(ram_en),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .frame_cnt(frame_cnt),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    // RAM model: write commits at the end of the cycle it is driven,
    // read data follows the driven address within the cycle
    logic [8:0] ramMem [1 << AW];
    always @(posedge clk) begin
        if (ram_en && ram_we) ramMem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = ramMem[ram_addr];

    // Logs every driven write address and flags we-without-en
    always @(negedge clk) begin
        if (ram_we && !ram_en) badAccess++;
        if (ram_en && ram_we) wrAddrQ.push_back(int'(ram_addr));
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] data;
        logic       eof;
        logic       rd;
        logic       expReady;
        logic [7:0] expData;
        logic       expEn;
        logic       expWe;
        logic [3:0] expAddr;
        logic [8:0] expWdata;
        logic [7:0] expFc;
        logic       expUr;
    } vec_t;

    vec_t vecs [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic wr, input logic [7:0] d,
                                 input logic e, input logic rd);
        reset    = r;
        enc_wr   = wr;
        enc_data = d;
        enc_eof  = e;
        mem_rd   = rd;
        tick();
    endtask

    task automatic clearInputs();
        reset = 1'b0; flush = 1'b0; enc_wr = 1'b0; enc_data = 8'h00;
        enc_eof = 1'b0; mem_rd = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic writeByte(input logic [7:0] d, input logic e);
        int n = 0;
        while (!enc_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("write ready", 32'(enc_ready), 32'h1);
        enc_wr = 1'b1; enc_data = d; enc_eof = e;
        tick();
        enc_wr = 1'b0; enc_eof = 1'b0;
    endtask

    task automatic popByte(output logic [7:0] got);
        int n = 0;
        while (mem_data == 8'hFF && n < 20) begin
            tick();
            n++;
        end
        checkOutput("pop avail", 32'(mem_data != 8'hFF), 32'h1);
        got = mem_data;
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
    endtask

    initial begin
        logic [7:0] got;
        int         errs;
        int         n;
        logic [7:0] gotQ[$];
        logic [7:0] expFc [8];

        // ------------------------------------------------------------------
        // Basic flow, cycle by cycle
        //            rst   wr    data   eof   rd    rdy   mdata  en    we    addr  wdata    fc     ur
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 4'h0, 9'h000, 8'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 4'h0, 9'h000, 8'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 4'h0, 9'h011, 8'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 4'h0, 9'h011, 8'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 4'h1, 9'h022, 8'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 4'h2, 9'h133, 8'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 4'h2, 9'h133, 8'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 4'h1, 9'h133, 8'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 4'h1, 9'h133, 8'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 4'h1, 9'h133, 8'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 4'h2, 9'h133, 8'd1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 4'h2, 9'h133, 8'd1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 4'h2, 9'h133, 8'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 4'h2, 9'h133, 8'd0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 4'h2, 9'h133, 8'd0, 1'b1};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].eof, vecs[i].rd);
            checkOutput($sformatf("vec%0d enc_ready", i), 32'(enc_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d mem_data", i), 32'(mem_data), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d ram_en", i), 32'(ram_en), 32'(vecs[i].expEn));
            checkOutput($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(vecs[i].expWe));
            checkOutput($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].expWdata));
            checkOutput($sformatf("vec%0d frame_cnt", i), 32'(frame_cnt), 32'(vecs[i].expFc));
            checkOutput($sformatf("vec%0d underrun", i), 32'(underrun), 32'(vecs[i].expUr));
        end
        clearInputs();

        // ------------------------------------------------------------------
        // Underrun on an empty buffer, pointers must stay at zero
        doReset();
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        checkOutput("underrun set", 32'(underrun), 32'h1);
        checkOutput("underrun mem_data", 32'(mem_data), 32'hFF);
        repeat (3) tick();
        checkOutput("underrun sticky", 32'(underrun), 32'h1);
        checkOutput("underrun no access", 32'(ram_en), 32'h0);
        writeByte(8'h99, 1'b0);
        tick();
        checkOutput("underrun wr access", 32'({ram_en, ram_we}), 32'h3);
        checkOutput("underrun wr addr", 32'(ram_addr), 32'h0);
        tick();
        tick();
        checkOutput("underrun data", 32'(mem_data), 32'h99);

        // ------------------------------------------------------------------
        // Full buffer: 16 in RAM plus 1 in head, then wrap
        doReset();
        wrAddrQ.delete();
        for (int i = 0; i < 17; i++) writeByte(8'h40 + 8'(i), 1'b0);
        repeat (3) tick();
        checkOutput("full enc_ready", 32'(enc_ready), 32'h0);
        checkOutput("full head", 32'(mem_data), 32'h40);
        checkOutput("full wr count", 32'(wrAddrQ.size()), 32'd17);
        checkOutput("full wrap addr", 32'((wrAddrQ.size() > 16) ? wrAddrQ[16] : 99), 32'd0);
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        n = 0;
        while (!enc_ready && n < 3) begin
            tick();
            n++;
        end
        checkOutput("full ready after pop", 32'(enc_ready), 32'h1);
        writeByte(8'h51, 1'b0);
        repeat (3) tick();
        checkOutput("full next addr", 32'((wrAddrQ.size() > 17) ? wrAddrQ[17] : 99), 32'd1);
        for (int i = 0; i < 17; i++) begin
            popByte(got);
            checkOutput($sformatf("full drain %0d", i), 32'(got), 32'(8'h41 + 8'(i)));
        end
        repeat (4) tick();
        checkOutput("full drained empty", 32'(mem_data), 32'hFF);

        // ------------------------------------------------------------------
        // Contention: continuous enc_wr, mem_rd every 16 cycles, 100 bytes
        doReset();
        gotQ.delete();
        fork
            begin
                int i = 0;
                int cyc = 0;
                logic acc;
                enc_wr = 1'b1;
                while (i < 100 && cyc < 4000) begin
                    enc_data = 8'(i);
                    acc = enc_ready;
                    tick();
                    cyc++;
                    if (acc) i++;
                end
                enc_wr = 1'b0;
            end
            begin
                int cyc = 0;
                while (gotQ.size() < 100 && cyc < 4000) begin
                    repeat (15) tick();
                    cyc += 16;
                    if (mem_data != 8'hFF) begin
                        gotQ.push_back(mem_data);
                        mem_rd = 1'b1;
                        tick();
                        mem_rd = 1'b0;
                    end else begin
                        tick();
                    end
                end
            end
        join
        checkOutput("contention count", 32'(gotQ.size()), 32'd100);
        errs = 0;
        for (int i = 0; i < gotQ.size(); i++) if (gotQ[i] != 8'(i)) errs++;
        checkOutput("contention order errors", 32'(errs), 32'd0);
        checkOutput("contention empty", 32'(mem_data), 32'hFF);

        // ------------------------------------------------------------------
        // Flush while a read is pending with enc_wr and mem_rd active
        doReset();
        writeByte(8'h5A, 1'b1);
        tick();
        tick();
        checkOutput("flush pre read", 32'({ram_en, ram_we}), 32'h2);
        checkOutput("flush pre frame_cnt", 32'(frame_cnt), 32'd1);
        flush = 1'b1; enc_wr = 1'b1; enc_data = 8'h77; enc_eof = 1'b1; mem_rd = 1'b1;
        tick();
        clearInputs();
        checkOutput("flush frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("flush mem_data", 32'(mem_data), 32'hFF);
        checkOutput("flush enc_ready", 32'(enc_ready), 32'h1);
        checkOutput("flush underrun", 32'(underrun), 32'h0);
        wrAddrQ.delete();
        repeat (4) tick();
        checkOutput("flush late rdata", 32'(mem_data), 32'hFF);
        checkOutput("flush no write", 32'(wrAddrQ.size()), 32'd0);
        checkOutput("flush no access", 32'(ram_en), 32'h0);

        // ------------------------------------------------------------------
        // Frame counting: frames of 1, 5 and 2 bytes
        doReset();
        writeByte(8'h01, 1'b1);
        checkOutput("frames after 1", 32'(frame_cnt), 32'd1);
        for (int i = 2; i <= 5; i++) writeByte(8'(i), 1'b0);
        writeByte(8'h06, 1'b1);
        checkOutput("frames after 2", 32'(frame_cnt), 32'd2);
        writeByte(8'h07, 1'b0);
        writeByte(8'h08, 1'b1);
        checkOutput("frames after 3", 32'(frame_cnt), 32'd3);
        expFc = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0};
        for (int i = 0; i < 8; i++) begin
            popByte(got);
            checkOutput($sformatf("frame pop data %0d", i), 32'(got), 32'(i + 1));
            checkOutput($sformatf("frame pop cnt %0d", i), 32'(frame_cnt), 32'(expFc[i]));
        end

        // Simultaneous eof accept and eof pop leave the count unchanged
        writeByte(8'h21, 1'b1);
        n = 0;
        while (mem_data != 8'h21 && n < 10) begin
            tick();
            n++;
        end
        checkOutput("simul head", 32'(mem_data), 32'h21);
        checkOutput("simul ready", 32'(enc_ready), 32'h1);
        enc_wr = 1'b1; enc_data = 8'h22; enc_eof = 1'b1; mem_rd = 1'b1;
        tick();
        clearInputs();
        checkOutput("simul frame_cnt", 32'(frame_cnt), 32'd1);
        popByte(got);
        checkOutput("simul second data", 32'(got), 32'h22);
        checkOutput("simul final cnt", 32'(frame_cnt), 32'd0);

        // Pop in the same cycle the prefetch lands
        repeat (3) tick();
        writeByte(8'h31, 1'b1);
        tick();
        tick();
        mem_rd = 1'b1;
        tick();
        mem_rd = 1'b0;
        checkOutput("landing pop cnt", 32'(frame_cnt), 32'd0);
        checkOutput("landing pop data", 32'(mem_data), 32'hFF);
        checkOutput("landing pop underrun", 32'(underrun), 32'h0);
        repeat (3) tick();
        checkOutput("landing pop no dup", 32'(mem_data), 32'hFF);

        checkOutput("ram we without en", 32'(badAccess), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
